// File: rtl/serial_mailbox.sv
// serial_mailbox: buffered serial I/O between the CPU serial handshake and the external link.
// Ports: Clock/Reset; link RX (LinkRxValid/LinkRxData); link TX (LinkTxValid/LinkTxReady/LinkTxData);
//        CPU side (SerialRead/SerialValid/SerialDataIn, SerialSend/SerialDataOut); TxFull, RxCount,
//        TxCount, ClearFlags and the packed Status word.

// mbox_fifo: first-word-fall-through FIFO with occupancy count.
// Latency: a word pushed at edge N is at the head after edge N; head is 0 when empty.
// Backpressure: a push while full is dropped (push_drop) unless a pop happens the same cycle.
module mbox_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic [DATA_W-1:0] head_dat,
   output logic [CNT_W-1:0]  cnt,
   output logic              empty,
   output logic              push_drop
);
   localparam int PTR_W = CNT_W - 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign cnt      = cnt_q;
   assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

   // A full FIFO still takes a push when the head leaves in the same cycle:
   // the write lands in the slot being vacated.
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign push_drop = push & ~do_push;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset: stale entries are never visible because the head is masked when empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// serial_mailbox: independent RX/TX FIFOs plus sticky error flags and a CPU-readable status word.
// Latency: one edge from push to head on either path; all outputs come from registered state.
// Backpressure: TX drains on LinkTxValid&LinkTxReady; RX has no link backpressure, overflow drops and flags.
module serial_mailbox #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              LinkRxValid,
   input  logic [DATA_W-1:0] LinkRxData,
   input  logic              LinkTxReady,
   output logic              LinkTxValid,
   output logic [DATA_W-1:0] LinkTxData,
   input  logic              SerialRead,
   output logic              SerialValid,
   output logic [DATA_W-1:0] SerialDataIn,
   input  logic              SerialSend,
   input  logic [DATA_W-1:0] SerialDataOut,
   output logic              TxFull,
   output logic [CNT_W-1:0]  RxCount,
   output logic [CNT_W-1:0]  TxCount,
   input  logic              ClearFlags,
   output logic [15:0]       Status
);
   logic       rx_empty, tx_empty;
   logic       rx_drop, tx_drop;
   logic       tx_pop;
   logic       rx_ovf_q, rx_ovf_d;
   logic       rx_unf_q, rx_unf_d;
   logic       tx_ovf_q, tx_ovf_d;
   logic [7:0] rx_cnt8;

   mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
      .clk       (Clock),
      .rst       (Reset),
      .push      (LinkRxValid),
      .push_dat  (LinkRxData),
      .pop       (SerialRead),
      .head_dat  (SerialDataIn),
      .cnt       (RxCount),
      .empty     (rx_empty),
      .push_drop (rx_drop)
   );

   assign tx_pop = LinkTxValid & LinkTxReady;

   mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
      .clk       (Clock),
      .rst       (Reset),
      .push      (SerialSend),
      .push_dat  (SerialDataOut),
      .pop       (tx_pop),
      .head_dat  (LinkTxData),
      .cnt       (TxCount),
      .empty     (tx_empty),
      .push_drop (tx_drop)
   );

   assign SerialValid = ~rx_empty;
   assign LinkTxValid = ~tx_empty;
   assign TxFull      = (TxCount == CNT_W'(DEPTH));

   // Clear first, then OR in this cycle's event so a coincident event survives the clear.
   always_comb begin
      rx_ovf_d = (ClearFlags ? 1'b0 : rx_ovf_q) | rx_drop;
      rx_unf_d = (ClearFlags ? 1'b0 : rx_unf_q) | (SerialRead & rx_empty);
      tx_ovf_d = (ClearFlags ? 1'b0 : tx_ovf_q) | tx_drop;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rx_ovf_q <= 1'b0;
         rx_unf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
      end else begin
         rx_ovf_q <= rx_ovf_d;
         rx_unf_q <= rx_unf_d;
         tx_ovf_q <= tx_ovf_d;
      end
   end

   // RxCount occupies an 8-bit field: zero-extend narrow counts, truncate wide ones.
   generate
      if (CNT_W >= 8) begin : g_cnt_trunc
         assign rx_cnt8 = RxCount[7:0];
      end else begin : g_cnt_ext
         assign rx_cnt8 = {{(8 - CNT_W){1'b0}}, RxCount};
      end
   endgenerate

   assign Status = {rx_cnt8, 3'b000, tx_ovf_q, rx_unf_q, rx_ovf_q, TxFull, SerialValid};
endmodule

// File: doc/serial_mailbox.md
Name: serial_mailbox

Overview:
- Parametrised buffered serial I/O block between the CPU's serial handshake (SerialValid/SerialRead/SerialSend) and the external serial link.
- Replaces the single-word, unbuffered serial path with independent RX and TX FIFOs of configurable width and depth.
- Adds fill counts, sticky overflow/underflow flags and a packed status word the CPU controller can load through the ALU bus mux.

Parameters:
- DATA_W, 16, data word width.
- DEPTH, 8, entries per FIFO; must be a power of two and at least 2.
- CNT_W, 4, count width; must equal log2(DEPTH)+1.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- LinkRxValid  in  1  link presents a received word this cycle.
- LinkRxData  in  DATA_W  received word.
- LinkTxReady  in  1  link accepts the word on LinkTxData this cycle.
- LinkTxValid  out  1  TX FIFO not empty.
- LinkTxData  out  DATA_W  head of TX FIFO.
- SerialRead  in  1  CPU pops the RX head this cycle.
- SerialValid  out  1  RX FIFO not empty.
- SerialDataIn  out  DATA_W  head of RX FIFO.
- SerialSend  in  1  CPU pushes SerialDataOut this cycle.
- SerialDataOut  in  DATA_W  word from the CPU (ALU result S).
- TxFull  out  1  TX FIFO full.
- RxCount  out  CNT_W  RX occupancy, 0..DEPTH.
- TxCount  out  CNT_W  TX occupancy, 0..DEPTH.
- ClearFlags  in  1  synchronous clear of the sticky flags.
- Status  out  16  packed status word.

Behaviour:
- Reset (asynchronous) clears:
  - all read/write pointers and counts to 0;
  - RxOverflow, RxUnderflow, TxOverflow to 0.
  - Consequently SerialValid=0, LinkTxValid=0, TxFull=0, SerialDataIn=0, LinkTxData=0.
  - A reset mid-transfer discards all buffered words.
- Both FIFOs are first-word-fall-through:
  - head data is valid combinationally whenever the FIFO is non-empty;
  - a head output reads 0 when its FIFO is empty.
- Latency: a word pushed at edge N appears at the head (and valid rises) after edge N. It can be popped in cycle N+1.
- Count updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both take effect, including when full. A full FIFO with a simultaneous pop accepts the push.
- Empty push with no pop: the word becomes the head next cycle.
- Pointers are CNT_W-1 bits and wrap from DEPTH-1 to 0.
- RX push condition: LinkRxValid. If full and no SerialRead that cycle:
  - the word is dropped;
  - RxOverflow is set (sticky);
  - stored contents are unchanged.
- RX pop condition: SerialRead. If RX is empty:
  - no state change;
  - RxUnderflow is set (sticky).
- TX push condition: SerialSend. If full and no link pop that cycle:
  - the word is dropped;
  - TxOverflow is set (sticky).
- TX pop condition: LinkTxValid and LinkTxReady (valid/ready handshake). LinkTxValid does not depend combinationally on LinkTxReady.
- TxFull = (TxCount == DEPTH).
- ClearFlags zeroes all three sticky flags at the next edge. If a flag event occurs in the same cycle as ClearFlags, the set wins.
- Status layout:
  - bit0 SerialValid;
  - bit1 TxFull;
  - bit2 RxOverflow;
  - bit3 RxUnderflow;
  - bit4 TxOverflow;
  - bits[15:8] RxCount zero-extended (truncated if CNT_W>8);
  - other bits 0.
- No combinational path from SerialRead or SerialSend to any output.
- Outputs depend only on registered state.

Test Plan:
- Reset, then idle:
  - SerialValid=0, LinkTxValid=0, RxCount=0, TxCount=0, Status=0x0000.
  - Assert Reset mid-stream with 3 words queued: all counts return to 0 immediately, without waiting for a clock edge.
- RX fill and drain (DEPTH=8):
  - Push 0x1000..0x1007, then a 9th word 0xDEAD.
  - Required: RxCount=8, RxOverflow=1, Status=0x0805.
  - Then 8 pops return 0x1000..0x1007 in order; 0xDEAD is never seen.
- Simultaneous push and pop:
  - Full RX: push 0xBEEF with SerialRead in the same cycle. Count stays 8, RxOverflow stays 0, and 0xBEEF emerges last.
  - Empty TX: SerialSend 0x0042 with LinkTxReady=1. LinkTxValid rises only the next cycle, carrying 0x0042.
- TX backpressure:
  - Hold LinkTxReady=0 and push 8 words: TxFull=1.
  - A 9th push sets TxOverflow.
  - Release LinkTxReady: 8 words leave on consecutive cycles, then LinkTxValid=0.
- Underflow and flag clear:
  - SerialRead on empty RX: RxUnderflow=1, pointers unchanged.
  - ClearFlags alone clears it.
  - ClearFlags together with a new underflow leaves RxUnderflow=1.
- Wrap-around with DEPTH=4:
  - Run 20 interleaved push/pop cycles with random gaps.
  - Data order matches a scoreboard model, and count never exceeds 4.
